// File: rtl/tree_pkg.sv
// Shared definitions for the binary-search-tree block and its command front end.
package tree_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned ERR_W = 2;

    typedef logic [ERR_W-1:0] err_t;

    localparam err_t ERR_OK    = 2'b00;
    localparam err_t ERR_EMPTY = 2'b01;
    localparam err_t ERR_FULL  = 2'b10;
    localparam err_t ERR_BOTH  = 2'b11;

    // Insert with this key means clear-all in the tree.
    localparam logic [KEY_W-1:0] CLEAR_KEY = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE_F = 2'b01,
        ST_ISSUE_I = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Debouncer: output follows the input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing cycles; flip the state on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tree_cmd_front.sv
// Button/switch front end: turns each debounced press into one screened find/insert/clear strobe.
module tree_cmd_front
    import tree_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_find,
    input  logic             btn_insert,
    input  logic [KEY_W-1:0] sw,
    input  logic             buf_empty,
    input  logic             buf_full,
    input  logic             tree_ready,
    output logic             k0,
    output logic             k1,
    output logic [KEY_W-1:0] key,
    output logic             busy,
    output logic [ERR_W-1:0] err_code
);

    logic [SYNC_STAGES-1:0] find_sync;
    logic [SYNC_STAGES-1:0] ins_sync;
    logic [KEY_W-1:0]       sw_sync [SYNC_STAGES];

    logic   find_db, ins_db;
    logic   find_q, ins_q;
    logic   find_ev, ins_ev;
    state_t state;

    // Synchronise the asynchronous buttons and switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            find_sync <= '0;
            ins_sync  <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) sw_sync[i] <= '0;
        end else begin
            find_sync  <= {find_sync[SYNC_STAGES-2:0], btn_find};
            ins_sync   <= {ins_sync[SYNC_STAGES-2:0], btn_insert};
            sw_sync[0] <= sw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_find (
        .clk  (clk),
        .rst  (rst),
        .din  (find_sync[SYNC_STAGES-1]),
        .dout (find_db)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_insert (
        .clk  (clk),
        .rst  (rst),
        .din  (ins_sync[SYNC_STAGES-1]),
        .dout (ins_db)
    );

    // Registered rising-edge detect: one-cycle press events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            find_q  <= 1'b0;
            ins_q   <= 1'b0;
            find_ev <= 1'b0;
            ins_ev  <= 1'b0;
        end else begin
            find_q  <= find_db;
            ins_q   <= ins_db;
            find_ev <= find_db & ~find_q;
            ins_ev  <= ins_db & ~ins_q;
        end
    end

    // Command FSM; strobes, key, busy and err_code are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            k0       <= 1'b0;
            k1       <= 1'b0;
            key      <= '0;
            busy     <= 1'b0;
            err_code <= ERR_OK;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (find_ev && ins_ev) begin
                        err_code <= ERR_BOTH;
                        state    <= ST_RELEASE;
                        busy     <= 1'b1;
                    end else if (find_ev) begin
                        busy <= 1'b1;
                        if (buf_empty) begin
                            err_code <= ERR_EMPTY;
                            state    <= ST_RELEASE;
                        end else begin
                            err_code <= ERR_OK;
                            key      <= sw_sync[SYNC_STAGES-1];
                            k0       <= 1'b1;
                            state    <= ST_ISSUE_F;
                        end
                    end else if (ins_ev) begin
                        busy <= 1'b1;
                        if (sw_sync[SYNC_STAGES-1] == CLEAR_KEY) begin
                            err_code <= ERR_OK;
                            key      <= CLEAR_KEY;
                            k1       <= 1'b1;
                            state    <= ST_ISSUE_I;
                        end else if (buf_full) begin
                            err_code <= ERR_FULL;
                            state    <= ST_RELEASE;
                        end else begin
                            err_code <= ERR_OK;
                            key      <= sw_sync[SYNC_STAGES-1];
                            k1       <= 1'b1;
                            state    <= ST_ISSUE_I;
                        end
                    end
                end
                ST_ISSUE_F, ST_ISSUE_I: begin
                    if (tree_ready) begin
                        k0    <= 1'b0;
                        k1    <= 1'b0;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!find_db && !ins_db) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    k0    <= 1'b0;
                    k1    <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_cmd_front.sv
// Directed bench for tree_cmd_front with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_tree_cmd_front;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_find, btn_insert;
    logic [3:0] sw;
    logic       buf_empty, buf_full, tree_ready;
    logic       k0, k1;
    logic [3:0] key;
    logic       busy;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_pass   = 0;

    int xfer_f  = 0;
    int xfer_i  = 0;
    int k1_hi   = 0;
    int overlap = 0;

    tree_cmd_front #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_find   (btn_find),
        .btn_insert (btn_insert),
        .sw         (sw),
        .buf_empty  (buf_empty),
        .buf_full   (buf_full),
        .tree_ready (tree_ready),
        .k0         (k0),
        .k1         (k1),
        .key        (key),
        .busy       (busy),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Transfer/strobe observer sampled on the active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (k0 && tree_ready) xfer_f = xfer_f + 1;
            if (k1 && tree_ready) xfer_i = xfer_i + 1;
            if (k1) k1_hi = k1_hi + 1;
            if (k0 && k1) overlap = overlap + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40 && busy !== 1'b0; i++) step(1);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s: busy=%b required 0 within 40 cycles", name, busy);
        else n_pass++;
    endtask

    task automatic wait_strobe(input bit ins, input string name);
        int i;
        for (i = 0; i < 20 && (ins ? k1 : k0) !== 1'b1; i++) step(1);
        n_checks++;
        if ((ins ? k1 : k0) !== 1'b1) $display("FAIL %s: strobe=%b required 1 within 20 cycles", name, ins ? k1 : k0);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_find = 0; btn_insert = 0; sw = 0;
        buf_empty = 0; buf_full = 0; tree_ready = 1;
        step(3);
        n_checks++; if ({k0, k1} !== 2'b00) $display("FAIL reset_strobes: got %b required 00", {k0, k1}); else n_pass++;
        n_checks++; if (key !== 4'd0) $display("FAIL reset_key: got %0d required 0", key); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (err_code !== 2'b00) $display("FAIL reset_err: got %b required 00", err_code); else n_pass++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_find_press;
        int  base = xfer_f;
        bit  early = 0;
        sw = 4'd5; buf_empty = 0; tree_ready = 1;
        btn_find = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (k0 !== 1'b0) early = 1;
        end
        n_checks++; if (early) $display("FAIL find_latency_early: k0 rose before cycle 8"); else n_pass++;
        step(1);
        n_checks++; if (k0 !== 1'b1) $display("FAIL find_k0_cycle8: got %b required 1", k0); else n_pass++;
        n_checks++; if (key !== 4'd5) $display("FAIL find_key: got %0d required 5", key); else n_pass++;
        n_checks++; if (err_code !== 2'b00) $display("FAIL find_err: got %b required 00", err_code); else n_pass++;
        step(1);
        n_checks++; if (k0 !== 1'b0) $display("FAIL find_pulse_len: k0=%b required 0", k0); else n_pass++;
        step(10);
        n_checks++; if (busy !== 1'b1) $display("FAIL find_busy_held: got %b required 1", busy); else n_pass++;
        btn_find = 1'b0;
        wait_idle("find_release");
        n_checks++; if (xfer_f - base !== 1) $display("FAIL find_count: got %0d required 1", xfer_f - base); else n_pass++;
    endtask

    task automatic test_stalled_insert;
        int  base_x = xfer_i;
        int  base_h = k1_hi;
        bit  bad = 0;
        sw = 4'd11; tree_ready = 0; buf_full = 0;
        btn_insert = 1'b1;
        wait_strobe(1'b1, "stall_k1_rise");
        for (int i = 0; i < 5; i++) begin
            if (k1 !== 1'b1 || key !== 4'd11) bad = 1;
            step(1);
        end
        n_checks++; if (bad) $display("FAIL stall_hold: k1/key not held at 1/11 during stall"); else n_pass++;
        tree_ready = 1'b1;
        n_checks++; if (k1 !== 1'b1) $display("FAIL stall_ready_cycle: k1=%b required 1", k1); else n_pass++;
        step(1);
        n_checks++; if (k1 !== 1'b0) $display("FAIL stall_drop: k1=%b required 0", k1); else n_pass++;
        n_checks++; if (k1_hi - base_h !== 6) $display("FAIL stall_len: got %0d cycles required 6", k1_hi - base_h); else n_pass++;
        n_checks++; if (xfer_i - base_x !== 1) $display("FAIL stall_xfer: got %0d required 1", xfer_i - base_x); else n_pass++;
        btn_insert = 1'b0;
        wait_idle("stall_release");
    endtask

    task automatic test_screening;
        int bf = xfer_f;
        int bi = xfer_i;
        buf_empty = 1; sw = 4'd2; tree_ready = 1;
        btn_find = 1'b1; step(12);
        n_checks++; if (err_code !== 2'b01) $display("FAIL screen_empty_err: got %b required 01", err_code); else n_pass++;
        btn_find = 1'b0; wait_idle("screen_empty_release");
        buf_empty = 0; buf_full = 1; sw = 4'd9;
        btn_insert = 1'b1; step(12);
        n_checks++; if (err_code !== 2'b10) $display("FAIL screen_full_err: got %b required 10", err_code); else n_pass++;
        btn_insert = 1'b0; wait_idle("screen_full_release");
        n_checks++; if (xfer_f - bf !== 0 || xfer_i - bi !== 0) $display("FAIL screen_no_strobe: got f=%0d i=%0d required 0/0", xfer_f - bf, xfer_i - bi); else n_pass++;
        sw = 4'd0;
        btn_insert = 1'b1;
        wait_strobe(1'b1, "screen_clear_rise");
        n_checks++; if (key !== 4'd0) $display("FAIL screen_clear_key: got %0d required 0", key); else n_pass++;
        n_checks++; if (err_code !== 2'b00) $display("FAIL screen_clear_err: got %b required 00", err_code); else n_pass++;
        btn_insert = 1'b0; wait_idle("screen_clear_release");
        n_checks++; if (xfer_i - bi !== 1) $display("FAIL screen_clear_count: got %0d required 1", xfer_i - bi); else n_pass++;
        buf_full = 0;
    endtask

    task automatic test_bounce;
        int bi = xfer_i;
        bit seen_busy = 0;
        sw = 4'd6;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) btn_insert = ~btn_insert;
            step(1);
            if (busy !== 1'b0) seen_busy = 1;
        end
        btn_insert = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (busy !== 1'b0) seen_busy = 1;
        end
        n_checks++; if (seen_busy) $display("FAIL bounce_busy: busy went high, required 0"); else n_pass++;
        n_checks++; if (xfer_i - bi !== 0) $display("FAIL bounce_strobe: got %0d required 0", xfer_i - bi); else n_pass++;
    endtask

    task automatic test_both;
        int bf = xfer_f;
        int bi = xfer_i;
        sw = 4'd4; tree_ready = 1;
        btn_find = 1'b1; btn_insert = 1'b1;
        step(12);
        n_checks++; if (err_code !== 2'b11) $display("FAIL both_err: got %b required 11", err_code); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL both_busy: got %b required 1", busy); else n_pass++;
        btn_find = 1'b0; btn_insert = 1'b0;
        wait_idle("both_release");
        n_checks++; if (xfer_f - bf !== 0 || xfer_i - bi !== 0) $display("FAIL both_no_strobe: got f=%0d i=%0d required 0/0", xfer_f - bf, xfer_i - bi); else n_pass++;
        bf = xfer_f;
        btn_find = 1'b1; step(100); btn_find = 1'b0;
        wait_idle("hold_release");
        n_checks++; if (xfer_f - bf !== 1) $display("FAIL hold_single: got %0d required 1", xfer_f - bf); else n_pass++;
    endtask

    task automatic test_reset_mid_issue;
        int bf = xfer_f;
        sw = 4'd7; tree_ready = 0;
        btn_find = 1'b1;
        wait_strobe(1'b0, "rst_k0_rise");
        rst = 1'b1;
        #1;
        n_checks++; if ({k0, busy} !== 2'b00) $display("FAIL rst_async: k0/busy=%b required 00", {k0, busy}); else n_pass++;
        n_checks++; if (key !== 4'd0 || err_code !== 2'b00) $display("FAIL rst_async_key_err: key=%0d err=%b required 0/00", key, err_code); else n_pass++;
        btn_find = 1'b0;
        step(2);
        rst = 1'b0;
        tree_ready = 1'b1;
        step(10);
        n_checks++; if (xfer_f - bf !== 0) $display("FAIL rst_lost: got %0d transfers required 0", xfer_f - bf); else n_pass++;
        sw = 4'd3;
        btn_find = 1'b1;
        wait_strobe(1'b0, "rst_next_rise");
        n_checks++; if (key !== 4'd3) $display("FAIL rst_next_key: got %0d required 3", key); else n_pass++;
        btn_find = 1'b0;
        wait_idle("rst_next_release");
        n_checks++; if (xfer_f - bf !== 1) $display("FAIL rst_next_count: got %0d required 1", xfer_f - bf); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        btn_find = 0; btn_insert = 0; sw = 0;
        buf_empty = 0; buf_full = 0; tree_ready = 1;
        test_reset;
        test_find_press;
        test_stalled_insert;
        test_screening;
        test_bounce;
        test_both;
        test_reset_mid_issue;
        n_checks++; if (overlap !== 0) $display("FAIL k0_k1_overlap: got %0d cycles required 0", overlap); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tree_cmd_front.md
# tree_cmd_front

Input front end for the binary-search-tree block. It synchronises and debounces the two raw push-buttons and the 4-bit switch bank. It then converts each press into exactly one find, insert or clear command toward the tree, using a ready handshake. Commands the tree cannot accept are screened out against its empty/full flags and reported on an error code.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a debounced button changes state (minimum 1).
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser (minimum 2).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_find  in  1  raw find button, asynchronous.
- btn_insert  in  1  raw insert/clear button, asynchronous.
- sw  in  4  raw key switches, asynchronous.
- buf_empty  in  1  tree holds no keys.
- buf_full  in  1  tree cannot take another key.
- tree_ready  in  1  tree accepts a strobe this cycle.
- k0  out  1  find strobe to tree.
- k1  out  1  insert strobe to tree; with key==0 it means clear-all.
- key  out  4  key for the strobe; stable while k0/k1 are high.
- busy  out  1  a command is pending or the block is waiting for button release.
- err_code  out  2  result of the last press: 00 ok, 01 find on empty, 10 insert on full, 11 both buttons pressed.

## Operation
- **Synchroniser:** btn_find, btn_insert and sw pass through SYNC_STAGES flip-flops.
- **Debounce:** each button has a counter. It resets whenever the synchronised input equals the debounced state. When the input differs for DEBOUNCE_CYCLES consecutive cycles, the debounced state flips and the counter clears. sw is only synchronised, not debounced.
- **Edge detect:** a registered rising edge of each debounced button produces a one-cycle press event.
- **FSM states:**
  - IDLE: evaluates press events and sw in the same cycle.
    - Find and insert events together: err_code=11, go to RELEASE, no strobe.
    - Find with buf_empty=1: err_code=01, go to RELEASE.
    - Find otherwise: latch key=sw, err_code=00, go to ISSUE_F.
    - Insert with sw==0: clear command, always allowed even when empty. Latch key=0, err_code=00, go to ISSUE_I.
    - Insert with sw!=0 and buf_full=1: err_code=10, go to RELEASE.
    - Insert otherwise: latch key, err_code=00, go to ISSUE_I.
  - ISSUE_F / ISSUE_I: drive k0 / k1 high with the latched key until a cycle in which tree_ready=1. That cycle is the transfer. Next cycle the strobe drops and the FSM enters RELEASE.
  - RELEASE: wait until both debounced buttons are low, then go to IDLE. This gives one command per press; a held button never repeats.
- **Held state:** err_code holds until the next evaluated press. buf_empty and buf_full are sampled only in IDLE; changes during ISSUE are ignored.
- **Outputs:** busy = (state != IDLE). key is 4 bits, zero-extended nowhere, with no arithmetic on it.

## Timing
- Reset values: k0=0, k1=0, key=0, busy=0, err_code=00, state=IDLE, debounced states=0, counters=0, synchronisers=0.
- Press latency, from raw edge to first strobe cycle: SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles (edge register plus FSM register).
- Strobe length: 1 cycle if tree_ready is already high, otherwise held until tree_ready. Exactly one cycle has k&&tree_ready per command.
- k0 and k1 are never high together.
- All outputs are registered; there is no combinational path from any input to k0, k1 or key.
- Reset mid-ISSUE: the strobe drops asynchronously and the command is lost; the tree sees no partial transfer.
- Bounce shorter than DEBOUNCE_CYCLES: no event.
- Release during ISSUE: the command still completes, then RELEASE exits immediately.

## Structure
- Shared package tree_pkg holds:
  - KEY_W=4.
  - Error code constants ERR_OK, ERR_EMPTY, ERR_FULL, ERR_BOTH.
  - FSM state encoding.
  - CLEAR_KEY=0, shared with the tree block.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, din, dout) is instantiated twice; its counter width is clog2(DEBOUNCE_CYCLES+1).
- The synchroniser is inline.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- **Find press:** sw=5, buf_empty=0, tree_ready=1; btn_find held 20 cycles -> one k0 pulse of 1 cycle with key=5, 8 cycles after the press; err_code=00; busy until release.
- **Stalled insert:** sw=11, tree_ready=0 for 5 cycles then 1 -> k1 held 6 cycles with key=11, dropped the cycle after ready.
- **Screening:** find with buf_empty=1 -> no strobe, err_code=01. Insert sw=9 with buf_full=1 -> err_code=10. Insert sw=0 with buf_full=1 -> k1 pulse with key=0.
- **Bounce:** btn_insert toggling every 2 cycles for 30 cycles then low -> no strobe, busy stays 0.
- **Both buttons:** same cycle -> err_code=11, no strobe. Holding btn_find 100 cycles -> exactly one k0.
- **Reset:** rst asserted while k0 is high -> k0, busy, key and err_code at reset values on the same edge; the next press works normally.
